// File: rtl/memctrl.sv
// rtl/memctrl.sv - byte-serial memory controller for instruction fetch and load/store requests
//
// Purpose: serialises word fetches and byte/half/word loads/stores into single-byte
// RAM cycles, assembling/splitting little-endian data, and returns a one-cycle
// done pulse to the requester.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes state and outputs, forces mem_wr low
//   rollback            pipeline flush; aborts fetches and non-IO loads
//   mem_din/mem_dout    RAM read byte (one cycle after address) / RAM write byte
//   mem_a, mem_wr       RAM byte address, write strobe
//   io_buffer_full      IO write buffer full (used only with MEMCTRL_IO_STALL_EN)
//   if_en/if_pc         fetch request and word address
//   if_done/if_data     fetch completion pulse and fetched word
//   lsb_en/lsb_wr/lsb_addr/lsb_len/lsb_w_data   load/store request fields
//   lsb_done/lsb_r_data load/store completion pulse and zero-filled load data
//
// Configuration macro: MEMCTRL_IO_STALL_EN - when defined, IO write bytes wait for
// io_buffer_full to drop and consecutive IO write bytes are separated by an idle cycle.
module memctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int IO_SEL_HI  = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  rollback,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  input  logic                  if_en,
  input  logic [31:0]           if_pc,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  lsb_en,
  input  logic                  lsb_wr,
  input  logic [31:0]           lsb_addr,
  input  logic [2:0]            lsb_len,
  input  logic [31:0]           lsb_w_data,
  output logic                  lsb_done,
  output logic [31:0]           lsb_r_data
);

`ifdef MEMCTRL_IO_STALL_EN
  localparam bit IO_STALL = 1'b1;
`else
  localparam bit IO_STALL = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, IF_READ, LSB_READ, LSB_WRITE} state_t;

  state_t                state, state_n;
  logic [2:0]            k, k_n;       // next byte index to put on the bus
  logic [2:0]            rk, rk_n;     // next byte index to capture from mem_din
  logic [2:0]            len, len_n;
  logic [31:0]           addr, addr_n;
  logic [31:0]           wdata, wdata_n;
  logic [31:0]           data, data_n;
  logic                  pend, pend_n; // mem_a this cycle is a live read address
  logic                  cap, cap_n;   // mem_din this cycle carries a wanted byte
  logic                  io_rd, io_rd_n;
  logic                  mem_wr_q, mem_wr_n;
  logic [ADDR_WIDTH-1:0] mem_a_n;
  logic [7:0]            mem_dout_n;
  logic                  if_done_n, lsb_done_n;
  logic [31:0]           if_data_n, lsb_r_data_n;

  // The RAM keeps answering the held address while frozen, so the byte that was
  // in flight when rdy dropped is saved and replayed on the first resumed cycle.
  logic                  frz;
  logic [7:0]            din_save;
  logic [7:0]            din_eff;

  logic [31:0]           byte_addr;
  logic [31:0]           merged;
  logic [7:0]            wbyte;
  logic                  prev_io_wr;
  logic                  hold_acc;
  logic                  hold_run;

  assign din_eff    = frz ? din_save : mem_din;
  assign byte_addr  = addr + {29'd0, k};
  assign merged     = data | ({24'd0, din_eff} << {rk[1:0], 3'b000});
  assign prev_io_wr = mem_wr_q && (mem_a[IO_SEL_HI -: 2] == 2'b11);
  assign hold_acc   = IO_STALL && (lsb_addr[IO_SEL_HI -: 2] == 2'b11) && io_buffer_full;
  assign hold_run   = IO_STALL && (byte_addr[IO_SEL_HI -: 2] == 2'b11) &&
                      (io_buffer_full || prev_io_wr);

  // A write strobe must never be seen by the RAM while the core is frozen.
  assign mem_wr = mem_wr_q & rdy;

  always_comb begin
    case (k[1:0])
      2'd0:    wbyte = wdata[7:0];
      2'd1:    wbyte = wdata[15:8];
      2'd2:    wbyte = wdata[23:16];
      default: wbyte = wdata[31:24];
    endcase
  end

  always_comb begin
    state_n      = state;
    k_n          = k;
    rk_n         = rk;
    len_n        = len;
    addr_n       = addr;
    wdata_n      = wdata;
    data_n       = data;
    pend_n       = pend;
    cap_n        = cap;
    io_rd_n      = io_rd;
    mem_wr_n     = 1'b0;
    mem_a_n      = mem_a;
    mem_dout_n   = mem_dout;
    if_done_n    = 1'b0;
    lsb_done_n   = 1'b0;
    if_data_n    = if_data;
    lsb_r_data_n = lsb_r_data;

    case (state)
      IDLE: begin
        if (!rollback) begin
          if (lsb_en && !lsb_done) begin
            addr_n  = lsb_addr;
            len_n   = lsb_len;
            wdata_n = lsb_w_data;
            data_n  = 32'd0;
            rk_n    = 3'd0;
            cap_n   = 1'b0;
            io_rd_n = (lsb_addr[IO_SEL_HI -: 2] == 2'b11);
            mem_a_n = lsb_addr[ADDR_WIDTH-1:0];
            if (lsb_wr) begin
              state_n = LSB_WRITE;
              pend_n  = 1'b0;
              if (hold_acc) begin
                k_n = 3'd0;
              end else begin
                mem_wr_n   = 1'b1;
                mem_dout_n = lsb_w_data[7:0];
                k_n        = 3'd1;
              end
            end else begin
              state_n = LSB_READ;
              pend_n  = 1'b1;
              k_n     = 3'd1;
            end
          end else if (if_en && !if_done) begin
            state_n = IF_READ;
            addr_n  = if_pc;
            len_n   = 3'd4;
            data_n  = 32'd0;
            rk_n    = 3'd0;
            cap_n   = 1'b0;
            pend_n  = 1'b1;
            k_n     = 3'd1;
            io_rd_n = 1'b0;
            mem_a_n = if_pc[ADDR_WIDTH-1:0];
          end
        end
      end

      IF_READ, LSB_READ: begin
        // IO reads have side effects and are only issued when committed, so a
        // flush must not cut them short.
        if (rollback && (state == IF_READ || !io_rd)) begin
          state_n = IDLE;
        end else begin
          cap_n = pend;
          if (k < len) begin
            mem_a_n = byte_addr[ADDR_WIDTH-1:0];
            k_n     = k + 3'd1;
            pend_n  = 1'b1;
          end else begin
            pend_n  = 1'b0;
          end
          if (cap) begin
            data_n = merged;
            rk_n   = rk + 3'd1;
            if (rk == len - 3'd1) begin
              state_n = IDLE;
              if (state == IF_READ) begin
                if_done_n = 1'b1;
                if_data_n = merged;
              end else begin
                lsb_done_n   = 1'b1;
                lsb_r_data_n = merged;
              end
            end
          end
        end
      end

      LSB_WRITE: begin
        if (k == len) begin
          state_n    = IDLE;
          lsb_done_n = 1'b1;
        end else if (!hold_run) begin
          mem_a_n    = byte_addr[ADDR_WIDTH-1:0];
          mem_dout_n = wbyte;
          mem_wr_n   = 1'b1;
          k_n        = k + 3'd1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= 3'd0;
      rk         <= 3'd0;
      len        <= 3'd0;
      addr       <= 32'd0;
      wdata      <= 32'd0;
      data       <= 32'd0;
      pend       <= 1'b0;
      cap        <= 1'b0;
      io_rd      <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_a      <= '0;
      mem_dout   <= 8'd0;
      if_done    <= 1'b0;
      lsb_done   <= 1'b0;
      if_data    <= 32'd0;
      lsb_r_data <= 32'd0;
      frz        <= 1'b0;
      din_save   <= 8'd0;
    end else begin
      frz <= ~rdy;
      if (!rdy && !frz) begin
        din_save <= mem_din;
      end
      if (rdy) begin
        state      <= state_n;
        k          <= k_n;
        rk         <= rk_n;
        len        <= len_n;
        addr       <= addr_n;
        wdata      <= wdata_n;
        data       <= data_n;
        pend       <= pend_n;
        cap        <= cap_n;
        io_rd      <= io_rd_n;
        mem_wr_q   <= mem_wr_n;
        mem_a      <= mem_a_n;
        mem_dout   <= mem_dout_n;
        if_done    <= if_done_n;
        lsb_done   <= lsb_done_n;
        if_data    <= if_data_n;
        lsb_r_data <= lsb_r_data_n;
      end
    end
  end

endmodule

// File: tb/tb_memctrl.sv
// tb/tb_memctrl.sv - directed self-checking bench for memctrl
module tb_memctrl;
  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;
  logic        if_en;
  logic [31:0] if_pc;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_en, lsb_wr;
  logic [31:0] lsb_addr;
  logic [2:0]  lsb_len;
  logic [31:0] lsb_w_data;
  logic        lsb_done;
  logic [31:0] lsb_r_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] ram [0:65535];

  typedef struct {
    int          c;
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_data[$];

  always #5 clk = ~clk;

  memctrl #(.ADDR_WIDTH(32), .IO_SEL_HI(17)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
    .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_w_data(lsb_w_data), .lsb_done(lsb_done), .lsb_r_data(lsb_r_data)
  );

  // Synchronous-read RAM: byte appears one cycle after its address. IO space is not stored.
  always @(posedge clk) begin
    mem_din <= ram[mem_a[15:0]];
    if (mem_wr && mem_a[17:16] != 2'b11) ram[mem_a[15:0]] <= mem_dout;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && mem_wr === 1'b1) begin
      checks++;
      assert (exp_wr.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed=%h:%h expected=none cyc=%0d", mem_a, mem_dout, cyc);
      end
      if (exp_wr.size() != 0) begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("wr_cycle", cyc, e.c);
        chk("wr_addr", mem_a, e.a);
        chk("wr_data", {24'd0, mem_dout}, {24'd0, e.d});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_wr(input int c, input logic [31:0] a, input logic [7:0] d);
    wr_t e;
    e.c = c;
    e.a = a;
    e.d = d;
    exp_wr.push_back(e);
  endtask

  task automatic chk_data(input string tag, input logic [31:0] obs);
    checks++;
    assert (exp_data.size() != 0) else begin
      errors++;
      $error("FAIL %s observed=%h expected=none", tag, obs);
    end
    if (exp_data.size() != 0) chk(tag, obs, exp_data.pop_front());
  endtask

  task automatic await_done(input bit is_if, input int budget, output int at);
    at = -1000;
    for (int i = 0; i < budget; i++) begin
      step();
      if ((is_if ? if_done : lsb_done) === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Requester keeps en high through the done cycle, as a registered requester would.
  task automatic release_lsb();
    step();
    chk("lsb_done_pulse", lsb_done, 0);
    lsb_en = 1'b0;
  endtask

  task automatic release_if();
    step();
    chk("if_done_pulse", if_done, 0);
    if_en = 1'b0;
  endtask

  task automatic idle(input int n);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      if (lsb_done !== 1'b0 || if_done !== 1'b0 || mem_wr !== 1'b0) bad = 1'b1;
    end
    chk("idle_quiet", bad, 0);
  endtask

  task automatic start_lsb(input bit wr, input logic [31:0] a, input logic [2:0] n, input logic [31:0] wd);
    lsb_en     = 1'b1;
    lsb_wr     = wr;
    lsb_addr   = a;
    lsb_len    = n;
    lsb_w_data = wd;
  endtask

  initial begin
    int t0;
    int at;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0100] = 8'h11; ram[16'h0101] = 8'h22; ram[16'h0102] = 8'h33; ram[16'h0103] = 8'h44;
    ram[16'h0400] = 8'h01; ram[16'h0401] = 8'h02; ram[16'h0402] = 8'h03; ram[16'h0403] = 8'h04;
    ram[16'h0300] = 8'h5A; ram[16'hFFFF] = 8'hAB; ram[16'h0000] = 8'hCD;
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
    if_en = 1'b0; if_pc = 32'd0;
    lsb_en = 1'b0; lsb_wr = 1'b0; lsb_addr = 32'd0; lsb_len = 3'd0; lsb_w_data = 32'd0;
    step(); step(); step();
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_lsb_done", lsb_done, 0);
    chk("rst_lsb_r_data", lsb_r_data, 0);
    rst = 1'b0;
    step();

    // Word load
    t0 = cyc;
    start_lsb(1'b0, 32'h100, 3'd4, 32'd0);
    exp_data.push_back(32'h44332211);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("ld4_mem_a", mem_a, 32'h100 + c - 1);
      chk("ld4_mem_wr", mem_wr, 0);
    end
    await_done(1'b0, 8, at);
    chk("ld4_done_cycle", at - t0, 6);
    chk_data("ld4_data", lsb_r_data);
    release_lsb();
    idle(6);

    // Half store
    t0 = cyc;
    push_wr(t0 + 1, 32'h200, 8'hDD);
    push_wr(t0 + 2, 32'h201, 8'hCC);
    start_lsb(1'b1, 32'h200, 3'd2, 32'hAABBCCDD);
    await_done(1'b0, 8, at);
    chk("st2_done_cycle", at - t0, 3);
    chk("st2_wr_low_at_done", mem_wr, 0);
    release_lsb();
    idle(4);
    chk("st2_ram_lo", {24'd0, ram[16'h0200]}, 32'hDD);

    // LSB and fetch together: LSB first, then fetch
    t0 = cyc;
    start_lsb(1'b0, 32'h300, 3'd1, 32'd0);
    if_en = 1'b1; if_pc = 32'h400;
    exp_data.push_back(32'h0000005A);
    exp_data.push_back(32'h04030201);
    await_done(1'b0, 8, at);
    chk("arb_lsb_done_cycle", at - t0, 3);
    chk("arb_if_not_yet", if_done, 0);
    chk_data("arb_lsb_data", lsb_r_data);
    release_lsb();
    await_done(1'b1, 12, at);
    chk("arb_if_done_cycle", at - t0, 9);
    chk_data("arb_if_data", if_data);
    release_if();
    idle(4);

    // Rollback aborts a fetch
    if_en = 1'b1; if_pc = 32'h400;
    step(); step(); step();
    rollback = 1'b1; if_en = 1'b0;
    step();
    rollback = 1'b0;
    idle(8);
    t0 = cyc;
    if_en = 1'b1; if_pc = 32'h400;
    exp_data.push_back(32'h04030201);
    await_done(1'b1, 10, at);
    chk("rb_refetch_done_cycle", at - t0, 6);
    chk_data("rb_refetch_data", if_data);
    release_if();

    // Rollback during a store does not stop it
    t0 = cyc;
    push_wr(t0 + 1, 32'h500, 8'h04);
    push_wr(t0 + 2, 32'h501, 8'h03);
    push_wr(t0 + 3, 32'h502, 8'h02);
    push_wr(t0 + 4, 32'h503, 8'h01);
    start_lsb(1'b1, 32'h500, 3'd4, 32'h01020304);
    step(); step();
    rollback = 1'b1;
    step();
    rollback = 1'b0;
    await_done(1'b0, 8, at);
    chk("rb_store_done_cycle", at - t0, 5);
    release_lsb();

    // Rollback in IDLE defers acceptance by one cycle
    t0 = cyc;
    start_lsb(1'b0, 32'h100, 3'd1, 32'd0);
    rollback = 1'b1;
    exp_data.push_back(32'h00000011);
    step();
    rollback = 1'b0;
    await_done(1'b0, 8, at);
    chk("rb_idle_done_cycle", at - t0, 4);
    chk_data("rb_idle_data", lsb_r_data);
    release_lsb();

    // rdy low three cycles mid-load
    t0 = cyc;
    start_lsb(1'b0, 32'h100, 3'd4, 32'd0);
    exp_data.push_back(32'h44332211);
    step(); step();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) step();
      chk("frz_mem_a", mem_a, 32'h101);
      chk("frz_mem_wr", mem_wr, 0);
    end
    step();
    rdy = 1'b1;
    await_done(1'b0, 10, at);
    chk("frz_done_cycle", at - t0, 9);
    chk_data("frz_data", lsb_r_data);
    release_lsb();

    // rdy low during a store masks mem_wr
    t0 = cyc;
    push_wr(t0 + 2, 32'h600, 8'h77);
    push_wr(t0 + 3, 32'h601, 8'h66);
    start_lsb(1'b1, 32'h600, 3'd2, 32'h00006677);
    step();
    rdy = 1'b0;
    #1;
    chk("frz_st_mem_wr", mem_wr, 0);
    step();
    rdy = 1'b1;
    await_done(1'b0, 8, at);
    chk("frz_st_done_cycle", at - t0, 4);
    release_lsb();

    // Address wraparound
    t0 = cyc;
    start_lsb(1'b0, 32'hFFFF_FFFF, 3'd2, 32'd0);
    exp_data.push_back(32'h0000CDAB);
    step();
    chk("wrap_a0", mem_a, 32'hFFFF_FFFF);
    step();
    chk("wrap_a1", mem_a, 32'h0000_0000);
    await_done(1'b0, 8, at);
    chk("wrap_done_cycle", at - t0, 4);
    chk_data("wrap_data", lsb_r_data);
    release_lsb();

    // IO store with the buffer full for five cycles
    t0 = cyc;
`ifdef MEMCTRL_IO_STALL_EN
    push_wr(t0 + 6, 32'h30000, 8'h41);
`else
    push_wr(t0 + 1, 32'h30000, 8'h41);
`endif
    start_lsb(1'b1, 32'h30000, 3'd1, 32'h00000041);
    io_buffer_full = 1'b1;
    at = -1000;
    for (int i = 0; i < 12 && at < 0; i++) begin
      step();
      if (cyc - t0 >= 5) io_buffer_full = 1'b0;
      if (lsb_done === 1'b1) at = cyc;
    end
    io_buffer_full = 1'b0;
`ifdef MEMCTRL_IO_STALL_EN
    chk("io_full_done_cycle", at - t0, 7);
`else
    chk("io_full_done_cycle", at - t0, 2);
`endif
    release_lsb();

    // Two-byte IO store: idle gap between bytes only when stalling is built in
    t0 = cyc;
    push_wr(t0 + 1, 32'h30010, 8'h66);
`ifdef MEMCTRL_IO_STALL_EN
    push_wr(t0 + 3, 32'h30011, 8'h55);
`else
    push_wr(t0 + 2, 32'h30011, 8'h55);
`endif
    start_lsb(1'b1, 32'h30010, 3'd2, 32'h00005566);
    await_done(1'b0, 8, at);
`ifdef MEMCTRL_IO_STALL_EN
    chk("io_gap_done_cycle", at - t0, 4);
`else
    chk("io_gap_done_cycle", at - t0, 3);
`endif
    release_lsb();

    // Reset mid-fetch abandons it
    if_en = 1'b1; if_pc = 32'h400;
    step(); step();
    rst = 1'b1; if_en = 1'b0;
    step();
    chk("rst_mid_if_done", if_done, 0);
    chk("rst_mid_mem_a", mem_a, 0);
    chk("rst_mid_if_data", if_data, 0);
    rst = 1'b0;
    idle(8);

    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("data_queue_drained", exp_data.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
